uart_bus_bridge: RTL
====================

# uart_bus_bridge

Memory-mapped bridge between the single-cycle MIPS data-memory bus and the UART transmitter/receiver pair. It decodes three word addresses in peripheral space, holds one outgoing byte, and runs a transmit-start handshake FSM toward the sender. It buffers received bytes in a small FIFO and raises a level interrupt to the CPU. It sits directly upstream of the UART sender and directly downstream of the UART receiver, replacing raw trigger wiring with a polled/interrupt register interface.

## Interface
- RX_DEPTH, 4: RX FIFO depth; power of two, 2..16.
- ADDR_TXD, 32'h4000_0018: TX data register address.
- ADDR_RXD, 32'h4000_001C: RX data register address.
- ADDR_CON, 32'h4000_0020: control/status register address.

- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- MemRead  in  1  bus read strobe.
- MemWrite  in  1  bus write strobe.
- Address  in  32  bus byte address; exact match against ADDR_* required.
- WriteData  in  32  bus write data.
- ReadData  out  32  combinational read data.
- rx_data  in  8  byte from receiver, valid with rx_valid.
- rx_valid  in  1  one-cycle pulse per received byte, synchronous to clk.
- tx_busy  in  1  sender busy level.
- tx_data  out  8  byte to sender, stable from tx_start until return to TX_IDLE.
- tx_start  out  1  registered one-cycle start pulse to sender.
- irq  out  1  registered level interrupt.

## Operation
- Registers: tx_hold[7:0], hold_full, tx_ie, rx_ie, rx_overrun, RX FIFO (rd/wr pointers with an extra wrap bit), TX FSM.
- Write to ADDR_TXD: if hold_full=0, load WriteData[7:0] and set hold_full. If hold_full=1, drop the write silently with no state change.
- Write to ADDR_CON: tx_ie<=WriteData[0], rx_ie<=WriteData[1]. WriteData[4]=1 clears rx_overrun. Bits [3:2] are read-only.
- Read of ADDR_CON returns {27'b0, rx_overrun, rx_avail, tx_ready, rx_ie, tx_ie}.
  - tx_ready = ~hold_full & (state==TX_IDLE).
  - rx_avail = FIFO not empty.
- Read of ADDR_RXD returns {24'b0, FIFO head} when non-empty, else 32'h0. A non-empty read pops at the clock edge that ends the read cycle; an empty read does not pop.
- ReadData is 0 when MemRead=0 or the address is unmapped. Reads of ADDR_TXD return {23'b0, hold_full, tx_hold}.
- Writes to ADDR_RXD and unmapped addresses are ignored.
- RX push on rx_valid:
  - FIFO not full: byte is written.
  - FIFO full: byte is dropped and rx_overrun is set (sticky).
  - Push and pop in the same cycle while full: both take effect, no overrun.
  - Push and pop in the same cycle while empty: the read returns 0 and the push succeeds.
- Pointer wrap is modulo RX_DEPTH. Full is detected when indices are equal and wrap bits differ.
- TX FSM:
  - TX_IDLE: if hold_full, then tx_data<=tx_hold, tx_start<=1, hold_full<=0, go to TX_WAIT_HI.
  - TX_WAIT_HI: tx_start<=0. On tx_busy=1, go to TX_WAIT_LO.
  - TX_WAIT_LO: on tx_busy=0, go to TX_IDLE.
- The CPU may reload tx_hold while the FSM is in TX_WAIT_HI or TX_WAIT_LO; that byte is launched on the next pass through TX_IDLE.
- irq <= (tx_ie & tx_ready) | (rx_ie & rx_avail) | (rx_ie & rx_overrun).
- A CPU write and FSM consumption of tx_hold never collide. A write is accepted only when hold_full=0, and the FSM consumes only when hold_full=1.

## Timing
- Reset values:
  - ReadData follows inputs (0 with MemRead=0).
  - tx_data=8'h00, tx_start=0, irq=0.
  - hold_full=0, tx_ie=0, rx_ie=0, rx_overrun=0.
  - FIFO empty, FSM in TX_IDLE.
- Reset asserted mid-transfer returns the FSM to TX_IDLE immediately. Pending and buffered bytes are lost.
- TXD write at edge N: hold_full=1 after N; tx_start=1 for the cycle after edge N+1; hold_full=0 after N+1.
- The sender must raise tx_busy within the transmission; the bridge waits indefinitely in TX_WAIT_HI.
- Minimum TX_IDLE→TX_IDLE round trip is 3 cycles.
- rx_valid at edge N makes rx_avail=1 after N and irq=1 after N+1 (when rx_ie=1).
- Read data is combinational in the same cycle as MemRead.

## Test plan
- Reset, then read ADDR_CON -> 32'h0000_0004 (tx_ready=1). irq=0, tx_start=0.
- Write 0x55 to TXD -> tx_start pulses one cycle 2 edges later with tx_data=8'h55. A second write of 0xAA during busy is accepted, then launched after tx_busy falls. A third write while hold_full=1 is dropped.
- Pulse rx_valid with 0x11, 0x22, 0x33 -> three RXD reads return 0x11, 0x22, 0x33, then 0x0. rx_avail clears after the third pop.
- Push 5 bytes with RX_DEPTH=4 -> CON bit4=1 and the first 4 bytes are intact. Write CON with bit4=1 -> overrun clears. Simultaneous rx_valid and RXD read while full -> no overrun.
- Set rx_ie=1, receive a byte -> irq=1 one edge after rx_avail. Pop it -> irq=0. Set tx_ie=1 in idle -> irq=1.
- Assert reset during TX_WAIT_LO with 2 bytes in the FIFO -> FSM in TX_IDLE, FIFO empty, CON reads 32'h0000_0004 after release.

Source files
------------

// File: rtl/uart_bus_bridge.sv
// Memory-mapped bridge between the MIPS data-memory bus and a UART sender/receiver pair.
// Three word registers: TXD (one-byte holding register), RXD (head of a small RX FIFO) and
// CON (interrupt enables plus status). A three-state handshake FSM hands each held byte to
// the sender and waits for its busy level to rise and fall again.
module uart_bus_bridge #(
  parameter int unsigned RX_DEPTH = 4,
  parameter logic [31:0] ADDR_TXD = 32'h4000_0018,
  parameter logic [31:0] ADDR_RXD = 32'h4000_001C,
  parameter logic [31:0] ADDR_CON = 32'h4000_0020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        irq
);

  localparam int unsigned PtrW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam logic [PtrW:0] PtrOne = {{PtrW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {TxIdle, TxWaitHi, TxWaitLo} tx_state_e;

  // Bus decode
  logic sel_txd, sel_rxd, sel_con;
  logic wr_txd, wr_con, rd_rxd;

  assign sel_txd = (Address == ADDR_TXD);
  assign sel_rxd = (Address == ADDR_RXD);
  assign sel_con = (Address == ADDR_CON);
  assign wr_txd  = MemWrite & sel_txd;
  assign wr_con  = MemWrite & sel_con;
  assign rd_rxd  = MemRead & sel_rxd;

  // Only WriteData[7:0] carries meaning (byte for TXD, control bits for CON)
  logic unused_wdata;
  assign unused_wdata = ^WriteData[31:8];

  // TX holding register and control state
  logic [7:0] tx_hold_q, tx_hold_d;
  logic       hold_full_q, hold_full_d;
  logic       tx_ie_q, rx_ie_q, rx_overrun_q;
  logic       tx_consume;
  logic       tx_ready;

  // TX FSM and its registered outputs
  tx_state_e  state_q, state_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_start_q, tx_start_d;
  logic       irq_q;

  // RX FIFO; pointers carry an extra wrap bit to tell full from empty
  logic [7:0]  fifo_mem [RX_DEPTH];
  logic [PtrW:0] rd_ptr_q, wr_ptr_q;
  logic        fifo_empty, fifo_full;
  logic        fifo_pop, fifo_push, overrun_set;
  logic [7:0]  fifo_head;

  assign fifo_empty = (rd_ptr_q == wr_ptr_q);
  assign fifo_full  = (rd_ptr_q[PtrW-1:0] == wr_ptr_q[PtrW-1:0]) &&
                      (rd_ptr_q[PtrW] != wr_ptr_q[PtrW]);
  assign fifo_head  = fifo_mem[rd_ptr_q[PtrW-1:0]];

  // A pop frees a slot in the same cycle, so a push while full still lands
  assign fifo_pop    = rd_rxd & ~fifo_empty;
  assign fifo_push   = rx_valid & (~fifo_full | fifo_pop);
  assign overrun_set = rx_valid & fifo_full & ~fifo_pop;

  assign tx_ready = ~hold_full_q & (state_q == TxIdle);

  // FIFO storage; contents are meaningless while the pointers say empty
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr_q[PtrW-1:0]] <= rx_data;
    end
  end

  // FIFO pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (fifo_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      if (fifo_push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
    end
  end

  // Holding register next state: FSM consumption and CPU load are mutually exclusive
  always_comb begin
    hold_full_d = hold_full_q;
    tx_hold_d   = tx_hold_q;
    if (tx_consume) begin
      hold_full_d = 1'b0;
    end else if (wr_txd && !hold_full_q) begin
      hold_full_d = 1'b1;
      tx_hold_d   = WriteData[7:0];
    end
  end

  // Holding register, control bits, sticky overrun and interrupt level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_hold_q    <= 8'h00;
      hold_full_q  <= 1'b0;
      tx_ie_q      <= 1'b0;
      rx_ie_q      <= 1'b0;
      rx_overrun_q <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      tx_hold_q   <= tx_hold_d;
      hold_full_q <= hold_full_d;
      if (wr_con) begin
        tx_ie_q <= WriteData[0];
        rx_ie_q <= WriteData[1];
        if (WriteData[4]) begin
          rx_overrun_q <= 1'b0;
        end
      end
      // A fresh overrun wins over a simultaneous clear
      if (overrun_set) begin
        rx_overrun_q <= 1'b1;
      end
      irq_q <= (tx_ie_q & tx_ready) | (rx_ie_q & ~fifo_empty) | (rx_ie_q & rx_overrun_q);
    end
  end

  // TX FSM state register with its registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= TxIdle;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  // TX FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TxIdle:   if (hold_full_q) state_d = TxWaitHi;
      TxWaitHi: if (tx_busy) state_d = TxWaitLo;
      TxWaitLo: if (!tx_busy) state_d = TxIdle;
      default:  state_d = TxIdle;
    endcase
  end

  // TX FSM outputs: launch the held byte on leaving idle
  always_comb begin
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    tx_consume = 1'b0;
    if (state_q == TxIdle && hold_full_q) begin
      tx_start_d = 1'b1;
      tx_data_d  = tx_hold_q;
      tx_consume = 1'b1;
    end
  end

  // Combinational read mux
  always_comb begin
    ReadData = 32'h0;
    if (MemRead) begin
      if (sel_con) begin
        ReadData = {27'b0, rx_overrun_q, ~fifo_empty, tx_ready, rx_ie_q, tx_ie_q};
      end else if (sel_rxd) begin
        ReadData = fifo_empty ? 32'h0 : {24'b0, fifo_head};
      end else if (sel_txd) begin
        ReadData = {23'b0, hold_full_q, tx_hold_q};
      end
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign irq      = irq_q;

endmodule
